tt_stim_capture: RTL and testbench

- Parametrised bench-side harness that sits between the cocotb-driven top and a tt_um_* user project.
- Sequences the DUT's active-low reset and enable, streams stimulus bytes onto ui_in/uio_in through a valid/ready handshake, and captures timestamped uo_out samples into a FIFO.
- Successor to the plain wire-up top: adds reset sequencing, multi-channel stimulus, a selectable capture mode and back-pressure.
- Synthesizable, so it can also be used in FPGA bring-up.

---
 rtl/tt_harness_pkg.sv | 30 +++
 rtl/tt_stim_capture_if.sv | 23 ++
 rtl/tt_sync_fifo.sv | 54 +++++
 rtl/tt_stim_capture.sv | 149 ++++++++++++++
 tb/tb_tt_stim_capture.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_harness_pkg.sv
// Shared types and defaults for the tt_stim_capture harness.
// State encoding, default parameters and capture-entry packing.
package tt_harness_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_TS_W       = 16;
  localparam int DEF_RST_CYCLES = 4;
  localparam bit DEF_CAP_ON_CHG = 1'b1;

  localparam int ENT_MAX_W = 96;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // {timestamp, sample}, right-aligned in a wide word;
  // callers keep the low TS_W+DATA_W bits.
  function automatic logic [ENT_MAX_W-1:0] pack_entry(
    input logic [63:0] ts,
    input logic [31:0] val,
    input int          val_w
  );
    return ({32'd0, ts} << val_w) | {64'd0, val};
  endfunction

endpackage

// File: rtl/tt_stim_capture_if.sv
// Stimulus (s_*) and capture (m_*) handshakes of the harness.
// master = bench/host side, slave = harness side.
interface tt_stim_capture_if #(
  parameter int DATA_W = 8,
  parameter int TS_W   = 16
);
  logic                   s_valid;
  logic                   s_ready;
  logic [2*DATA_W-1:0]    s_data;
  logic                   m_valid;
  logic                   m_ready;
  logic [TS_W+DATA_W-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/tt_sync_fifo.sv
// First-word-fall-through synchronous FIFO, power-of-two depth.
// Ports: push/push_data in, pop in, pop_data/full/empty out.
module tt_sync_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_pop;
  logic          do_push;

  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;

  // a pop in the same cycle frees the slot a full push needs
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/tt_stim_capture.sv
// Harness for a tt_um_* design: reset sequencing, stimulus, capture.
// Ports: clk/rst, bus (stim+capture handshakes), halt, status, dut_*.
module tt_stim_capture
  import tt_harness_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int TS_W          = DEF_TS_W,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter bit CAP_ON_CHANGE = DEF_CAP_ON_CHG
) (
  input  logic              clk,
  input  logic              rst,
  tt_stim_capture_if.slave  bus,
  input  logic              halt,
  output logic              overflow,
  output logic [1:0]        state_o,
  output logic              dut_rst_n,
  output logic              dut_ena,
  output logic [DATA_W-1:0] dut_ui_in,
  output logic [DATA_W-1:0] dut_uio_in,
  input  logic [DATA_W-1:0] dut_uo_out
);
  localparam int HC_W  = $clog2(RST_CYCLES + 1);
  localparam int ENT_W = TS_W + DATA_W;

  state_e state_q;
  state_e state_d;

  logic [HC_W-1:0]   hold_cnt;
  logic [TS_W-1:0]   ts_q;
  logic [DATA_W-1:0] last_q;
  logic              first_q;
  logic              ovf_q;
  logic              run;

  logic [ENT_MAX_W-1:0] ent_full;
  logic [ENT_W-1:0]     ent;
  logic                 want_push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 accepted;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RESET;
    else     state_q <= state_d;
  end

  // next state; halt is only looked at from RUN/HALT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_HOLD;
      ST_HOLD: begin
        if (hold_cnt == HC_W'(RST_CYCLES - 1))
          state_d = ST_RUN;
      end
      ST_RUN:  if (halt)  state_d = ST_HALT;
      ST_HALT: if (!halt) state_d = ST_RUN;
      default: state_d = ST_RESET;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    dut_rst_n   = 1'b0;
    dut_ena     = 1'b0;
    bus.s_ready = 1'b0;
    run         = 1'b0;
    unique case (state_q)
      ST_RESET: ;
      ST_HOLD:  dut_ena = 1'b1;
      ST_RUN: begin
        dut_rst_n   = 1'b1;
        dut_ena     = 1'b1;
        bus.s_ready = 1'b1;
        run         = 1'b1;
      end
      ST_HALT:  dut_rst_n = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_HOLD) hold_cnt <= '0;
    else                           hold_cnt <= hold_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)      ts_q <= '0;
    else if (run) ts_q <= ts_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dut_ui_in  <= '0;
      dut_uio_in <= '0;
    end else if (bus.s_valid && bus.s_ready) begin
      {dut_uio_in, dut_ui_in} <= bus.s_data;
    end
  end

  // change detector: first RUN cycle after reset always captures
  assign want_push = run && (!CAP_ON_CHANGE || first_q ||
                             dut_uo_out != last_q);
  assign pop       = bus.m_valid & bus.m_ready;
  assign accepted  = want_push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= 1'b1;
      last_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (run)      first_q <= 1'b0;
      if (accepted) last_q  <= dut_uo_out;
      if (want_push && !accepted) ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;

  assign ent_full = pack_entry(64'(ts_q), 32'(dut_uo_out), DATA_W);
  assign ent      = ent_full[ENT_W-1:0];

  logic [ENT_MAX_W-ENT_W-1:0] unused_ent_hi;
  assign unused_ent_hi = ent_full[ENT_MAX_W-1:ENT_W];

  tt_sync_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (want_push),
    .push_data (ent),
    .pop       (pop),
    .pop_data  (bus.m_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.m_valid = ~fifo_empty;

endmodule

// File: tb/tb_tt_stim_capture.sv
// Bench for tt_stim_capture: change-capture and capture-all instances
// driven in lockstep, checked against a queue model and literals.
module tb_tt_stim_capture;
  localparam int DW = 8;
  localparam int TW = 16;
  localparam int DEPTH = 16;
  localparam int RC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        halt;
  logic        s_valid;
  logic [15:0] s_data;
  logic [7:0]  uo;
  logic        mr_chg;
  logic        mr_all;

  int checks = 0;
  int errors = 0;

  tt_stim_capture_if #(.DATA_W(DW), .TS_W(TW)) bus_chg ();
  tt_stim_capture_if #(.DATA_W(DW), .TS_W(TW)) bus_all ();

  assign bus_chg.s_valid = s_valid;
  assign bus_chg.s_data  = s_data;
  assign bus_chg.m_ready = mr_chg;
  assign bus_all.s_valid = s_valid;
  assign bus_all.s_data  = s_data;
  assign bus_all.m_ready = mr_all;

  logic       ov_chg, rstn_chg, ena_chg;
  logic [1:0] st_chg;
  logic [7:0] ui_chg, uio_chg;
  logic       ov_all, rstn_all, ena_all;
  logic [1:0] st_all;
  logic [7:0] ui_all, uio_all;

  tt_stim_capture #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TS_W(TW),
    .RST_CYCLES(RC), .CAP_ON_CHANGE(1'b1)
  ) u_chg (
    .clk(clk), .rst(rst), .bus(bus_chg), .halt(halt),
    .overflow(ov_chg), .state_o(st_chg),
    .dut_rst_n(rstn_chg), .dut_ena(ena_chg),
    .dut_ui_in(ui_chg), .dut_uio_in(uio_chg),
    .dut_uo_out(uo)
  );

  tt_stim_capture #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TS_W(TW),
    .RST_CYCLES(RC), .CAP_ON_CHANGE(1'b0)
  ) u_all (
    .clk(clk), .rst(rst), .bus(bus_all), .halt(halt),
    .overflow(ov_all), .state_o(st_all),
    .dut_rst_n(rstn_all), .dut_ena(ena_all),
    .dut_ui_in(ui_all), .dut_uio_in(uio_all),
    .dut_uo_out(uo)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // ---- model: cycles since release, halt flag, entry queues ----
  int          m_t = 0;
  bit          m_halted = 0;
  bit          m_first = 1;
  logic [15:0] m_ts = '0;
  logic [7:0]  m_ui = '0;
  logic [7:0]  m_uio = '0;
  logic [23:0] q_chg[$];
  logic [23:0] q_all[$];
  bit          mov_chg = 0;
  bit          mov_all = 0;
  logic [7:0]  last_chg = '0;

  function automatic int exp_state();
    if (m_t == 0) return 0;
    if (m_t <= RC) return 1;
    if (m_halted) return 3;
    return 2;
  endfunction

  always @(posedge clk) begin
    int st;
    if (rst) begin
      m_t = 0; m_halted = 0; m_first = 1; m_ts = '0;
      m_ui = '0; m_uio = '0;
      q_chg.delete(); q_all.delete();
      mov_chg = 0; mov_all = 0; last_chg = '0;
    end else begin
      st = exp_state();
      if (mr_chg && q_chg.size() > 0) void'(q_chg.pop_front());
      if (mr_all && q_all.size() > 0) void'(q_all.pop_front());
      if (st == 2) begin
        if (s_valid) {m_uio, m_ui} = s_data;
        if (m_first || uo != last_chg) begin
          if (q_chg.size() < DEPTH) begin
            q_chg.push_back({m_ts, uo});
            last_chg = uo;
          end else mov_chg = 1;
        end
        if (q_all.size() < DEPTH) q_all.push_back({m_ts, uo});
        else mov_all = 1;
        m_first = 0;
        m_ts = m_ts + 16'd1;
        if (halt) m_halted = 1;
      end else if (st == 3) begin
        if (!halt) m_halted = 0;
      end
      if (m_t <= RC) m_t++;
    end
  end

  // ---- every-cycle comparison against the model ----
  always @(negedge clk) begin
    int st;
    st = exp_state();
    chk("state_chg", 64'(st_chg), 64'(st));
    chk("state_all", 64'(st_all), 64'(st));
    chk("rst_n", 64'(rstn_chg), 64'(st == 2 || st == 3));
    chk("ena", 64'(ena_all), 64'(st == 1 || st == 2));
    chk("s_ready", 64'(bus_chg.s_ready), 64'(st == 2));
    chk("ui", 64'({uio_chg, ui_chg}), 64'({m_uio, m_ui}));
    chk("ui_all", 64'({uio_all, ui_all}), 64'({m_uio, m_ui}));
    chk("ov_chg", 64'(ov_chg), 64'(mov_chg));
    chk("ov_all", 64'(ov_all), 64'(mov_all));
    chk("mv_chg", 64'(bus_chg.m_valid), 64'(q_chg.size() > 0));
    chk("mv_all", 64'(bus_all.m_valid), 64'(q_all.size() > 0));
    if (q_chg.size() > 0)
      chk("md_chg", 64'(bus_chg.m_data), 64'(q_chg[0]));
    if (q_all.size() > 0)
      chk("md_all", 64'(bus_all.m_data), 64'(q_all[0]));
  end

  task automatic hold_seq();
    for (int i = 1; i <= RC; i++) begin
      @(negedge clk);
      chk("lit_hold_st", 64'(st_chg), 64'd1);
      chk("lit_hold_rstn", 64'(rstn_chg), 64'd0);
      chk("lit_hold_ena", 64'(ena_chg), 64'd1);
    end
    @(negedge clk);
    chk("lit_run_st", 64'(st_chg), 64'd2);
    chk("lit_run_rstn", 64'(rstn_chg), 64'd1);
  endtask

  // ---- directed stimulus with literal expectations ----
  initial begin
    rst = 1; halt = 0; s_valid = 0; s_data = '0;
    uo = 8'd3; mr_chg = 1; mr_all = 0;
    repeat (3) @(negedge clk);
    chk("lit_rst_st", 64'(st_chg), 64'd0);
    chk("lit_rst_rstn", 64'(rstn_chg), 64'd0);
    chk("lit_rst_mv", 64'(bus_all.m_valid), 64'd0);
    chk("lit_rst_sr", 64'(bus_chg.s_ready), 64'd0);
    rst = 0;
    hold_seq();                      // ends at N5, RUN k0
    @(negedge clk);                  // N6
    chk("lit_first_mv", 64'(bus_chg.m_valid), 64'd1);
    chk("lit_first_md", 64'(bus_chg.m_data), 64'h000003);
    s_valid = 1; s_data = 16'hA55A;
    @(negedge clk);                  // N7
    chk("lit_ui", 64'(ui_chg), 64'h5A);
    chk("lit_uio", 64'(uio_chg), 64'hA5);
    chk("lit_chg_k1", 64'(bus_chg.m_valid), 64'd0);
    s_valid = 0;
    @(negedge clk);                  // N8
    chk("lit_chg_k2", 64'(bus_chg.m_valid), 64'd0);
    uo = 8'd7;
    @(negedge clk);                  // N9
    chk("lit_chg_e2", 64'(bus_chg.m_data), 64'h000307);
    chk("lit_chg_v2", 64'(bus_chg.m_valid), 64'd1);
    @(negedge clk);                  // N10
    chk("lit_chg_k4", 64'(bus_chg.m_valid), 64'd0);
    uo = 8'd1;
    @(negedge clk);                  // N11
    chk("lit_chg_e3", 64'(bus_chg.m_data), 64'h000501);
    chk("lit_chg_v3", 64'(bus_chg.m_valid), 64'd1);
    @(negedge clk);                  // N12
    chk("lit_chg_end", 64'(bus_chg.m_valid), 64'd0);
    repeat (5) @(negedge clk);       // N17
    chk("lit_ui_hold", 64'({uio_chg, ui_chg}), 64'hA55A);
    repeat (4) @(negedge clk);       // N21
    chk("lit_ov_pre", 64'(ov_all), 64'd0);
    @(negedge clk);                  // N22
    chk("lit_ov_set", 64'(ov_all), 64'd1);
    repeat (3) @(negedge clk);       // N25
    chk("lit_full_head", 64'(bus_all.m_data), 64'h000003);
    mr_all = 1;
    @(negedge clk);                  // N26
    mr_all = 0;
    chk("lit_pop_head", 64'(bus_all.m_data), 64'h000103);
    chk("lit_ov_sticky", 64'(ov_all), 64'd1);
    @(negedge clk);                  // N27
    halt = 1;
    @(negedge clk);                  // N28
    uo = 8'd9; mr_all = 1;
    @(negedge clk);                  // N29
    chk("lit_halt_st", 64'(st_chg), 64'd3);
    chk("lit_halt_ena", 64'(ena_chg), 64'd0);
    chk("lit_halt_sr", 64'(bus_chg.s_ready), 64'd0);
    repeat (2) @(negedge clk);       // N31
    chk("lit_halt_nocap", 64'(bus_chg.m_valid), 64'd0);
    @(negedge clk);                  // N32
    halt = 0;
    @(negedge clk);                  // N33
    chk("lit_resume_st", 64'(st_chg), 64'd2);
    @(negedge clk);                  // N34
    chk("lit_resume_ts", 64'(bus_chg.m_data), 64'h001709);
    repeat (6) @(negedge clk);       // N40
    mr_all = 0;
    repeat (10) @(negedge clk);      // N50
    chk("lit_pre_mv", 64'(bus_all.m_valid), 64'd1);
    rst = 1;
    @(negedge clk);                  // N51
    chk("lit_mrst_mv", 64'(bus_all.m_valid), 64'd0);
    chk("lit_mrst_ov", 64'(ov_all), 64'd0);
    chk("lit_mrst_ui", 64'(ui_all), 64'd0);
    chk("lit_mrst_rstn", 64'(rstn_all), 64'd0);
    rst = 0;
    hold_seq();
    @(negedge clk);
    chk("lit_mrst_first", 64'(bus_chg.m_data), 64'h000009);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
